store_monitor: RTL and testbench

Synthesizable self-check stage that sits directly downstream of the pipelined MIPS core's data-memory write port, in parallel with the data memory. It snoops every store (memwrite, dataadr, writedata), classifies it against a programmed pass/scratch address pair, and latches a sticky verdict with diagnostic counters. Board-level runs use it in place of a simulation-only checker; benches use it as a cycle-accurate oracle.

---
 rtl/store_monitor_pkg.sv | 19 +
 rtl/store_monitor_sat_counter.sv | 25 ++
 rtl/store_monitor.sv | 117 +++++++++++
 tb/tb_store_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg
//   Shared types for the store monitor: verdict state encoding and the
//   fail-code values reported on store_monitor.fail_code.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_BADADDR = 2'b01,
    FC_BADDATA = 2'b10,
    FC_TIMEOUT = 2'b11
  } fcode_t;

endpackage

// File: rtl/store_monitor_sat_counter.sv
// sat_counter
//   Up-counter that stops at its all-ones value instead of wrapping.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-low clear
//     en    - count enable (one increment per enabled edge)
//     count - current value, W bits
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/store_monitor.sv
// store_monitor
//   Snoops the core's data-memory write port and latches a sticky
//   pass/fail verdict. A store of PASS_DATA to PASS_ADDR passes; stores to
//   SCRATCH_ADDR are tolerated; anything else, wrong data at PASS_ADDR, or
//   TIMEOUT cycles without a verdict fails. Once decided, all state freezes
//   until reset.
//   Ports:
//     clk         - core clock, rising edge
//     reset       - asynchronous, active-low
//     memwrite    - store strobe (one cycle per store)
//     dataadr     - store byte address
//     writedata   - store data
//     done        - verdict valid (PASS or FAIL)
//     pass        - verdict is pass
//     fail_code   - 00 none, 01 bad address, 10 bad data, 11 timeout
//     store_count - stores seen while running, saturating
//     cycle_count - cycles spent running, saturating
//     last_addr   - address of most recent store seen while running
//     last_data   - data of most recent store seen while running
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'h0000_0310,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      last_addr,
  output logic [31:0]      last_data
);

  state_t state, next_state;
  fcode_t fc_q, next_fc;

  logic in_run;
  logic store;
  logic tmo;
  logic cyc_en;

  assign in_run = (state == RUN);
  assign store  = in_run && memwrite;
  assign tmo    = in_run && (cycle_count == CNT_W'(TIMEOUT - 1));
  // The timeout edge itself is not counted, so cycle_count freezes at
  // TIMEOUT-1 on a timeout.
  assign cyc_en = in_run && !tmo;

  always_comb begin
    next_state = state;
    next_fc    = fc_q;
    if (in_run) begin
      if (memwrite) begin
        if (dataadr == PASS_ADDR) begin
          if (writedata == PASS_DATA) begin
            next_state = PASS;
          end else begin
            next_state = FAIL;
            next_fc    = FC_BADDATA;
          end
        end else if (dataadr != SCRATCH_ADDR) begin
          next_state = FAIL;
          next_fc    = FC_BADADDR;
        end
      end
      // A store-driven verdict on the same edge takes priority.
      if ((next_state == RUN) && tmo) begin
        next_state = FAIL;
        next_fc    = FC_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      fc_q      <= FC_NONE;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      state <= next_state;
      fc_q  <= next_fc;
      if (store) begin
        last_addr <= dataadr;
        last_data <= writedata;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (store),
    .count (store_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cyc_en),
    .count (cycle_count)
  );

  assign done      = (state != RUN);
  assign pass      = (state == PASS);
  assign fail_code = fc_q;

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor
//   Scoreboard bench for store_monitor. Instance a uses TIMEOUT=16,
//   instance b uses CNT_W=4, TIMEOUT=15. Expected verdicts are queued
//   before stimulus; a monitor pops and compares on each rising done.
module tb_store_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, mw_a, rst_b, mw_b;
  logic [31:0] adr_a, wd_a, adr_b, wd_b;
  logic        done_a, pass_a, done_b, pass_b;
  logic [1:0]  fc_a, fc_b;
  logic [15:0] sc_a, cc_a;
  logic [3:0]  sc_b, cc_b;
  logic [31:0] la_a, ld_a, la_b, ld_b;

  store_monitor #(.TIMEOUT(16)) dut_a (
    .clk(clk), .reset(rst_a), .memwrite(mw_a), .dataadr(adr_a), .writedata(wd_a),
    .done(done_a), .pass(pass_a), .fail_code(fc_a), .store_count(sc_a),
    .cycle_count(cc_a), .last_addr(la_a), .last_data(ld_a)
  );

  store_monitor #(.CNT_W(4), .TIMEOUT(15)) dut_b (
    .clk(clk), .reset(rst_b), .memwrite(mw_b), .dataadr(adr_b), .writedata(wd_b),
    .done(done_b), .pass(pass_b), .fail_code(fc_b), .store_count(sc_b),
    .cycle_count(cc_b), .last_addr(la_b), .last_data(ld_b)
  );

  typedef struct {
    logic        p;
    logic [1:0]  fc;
    logic [15:0] sc;
    logic        ccv;
    logic [15:0] cc;
    logic [31:0] la;
    logic [31:0] ld;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   total = 0;
  int   bad   = 0;
  logic pda = 1'b0;
  logic pdb = 1'b0;

  function automatic exp_t mk(input logic p, input logic [1:0] fc, input logic [15:0] sc,
                              input logic ccv, input logic [15:0] cc,
                              input logic [31:0] la, input logic [31:0] ld);
    exp_t e;
    e.p = p; e.fc = fc; e.sc = sc; e.ccv = ccv; e.cc = cc; e.la = la; e.ld = ld;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input logic p, input logic [1:0] fc,
                     input logic [15:0] sc, input logic [15:0] cc,
                     input logic [31:0] la, input logic [31:0] ld);
    chk({who, ".pass"}, 32'(p), 32'(e.p));
    chk({who, ".fail_code"}, 32'(fc), 32'(e.fc));
    chk({who, ".store_count"}, 32'(sc), 32'(e.sc));
    if (e.ccv) chk({who, ".cycle_count"}, 32'(cc), 32'(e.cc));
    chk({who, ".last_addr"}, la, e.la);
    chk({who, ".last_data"}, ld, e.ld);
  endtask

  // Monitor: a rising done is the DUT presenting a verdict.
  always @(negedge clk) begin
    if (done_a && !pda) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a.unexpected_verdict actual=done required=none");
      end else begin
        ea = qa.pop_front();
        cmp("a", ea, pass_a, fc_a, sc_a, cc_a, la_a, ld_a);
      end
    end
    if (done_b && !pdb) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b.unexpected_verdict actual=done required=none");
      end else begin
        eb = qb.pop_front();
        cmp("b", eb, pass_b, fc_b, {12'b0, sc_b}, {12'b0, cc_b}, la_b, ld_b);
      end
    end
    pda <= done_a;
    pdb <= done_b;
  end

  task automatic wait_a(input int n);
    int k = 0;
    while (qa.size() != 0 && k < n) begin
      @(negedge clk); #1;
      k++;
    end
    total++;
    if (qa.size() != 0) begin
      bad++;
      $display("FAIL a.verdict_wait actual=pending required=empty");
      qa.delete();
    end
  endtask

  task automatic wait_b(input int n);
    int k = 0;
    while (qb.size() != 0 && k < n) begin
      @(negedge clk); #1;
      k++;
    end
    total++;
    if (qb.size() != 0) begin
      bad++;
      $display("FAIL b.verdict_wait actual=pending required=empty");
      qb.delete();
    end
  endtask

  task automatic st_a(input logic [31:0] a, input logic [31:0] d);
    mw_a = 1'b1; adr_a = a; wd_a = d;
    @(negedge clk);
    mw_a = 1'b0;
  endtask

  task automatic st_b(input logic [31:0] a, input logic [31:0] d);
    mw_b = 1'b1; adr_b = a; wd_b = d;
    @(negedge clk);
    mw_b = 1'b0;
  endtask

  task automatic rst_pulse_a();
    @(negedge clk); rst_a = 1'b0;
    @(negedge clk); rst_a = 1'b1;
  endtask

  task automatic rst_pulse_b();
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
  endtask

  initial begin
    rst_a = 1'b0; mw_a = 1'b0; adr_a = '0; wd_a = '0;
    rst_b = 1'b0; mw_b = 1'b0; adr_b = '0; wd_b = '0;
    #1;
    chk("rst.done", 32'(done_a), 0);
    chk("rst.pass", 32'(pass_a), 0);
    chk("rst.fail_code", 32'(fc_a), 0);
    chk("rst.store_count", 32'(sc_a), 0);
    chk("rst.cycle_count", 32'(cc_a), 0);
    chk("rst.last_addr", la_a, 0);
    chk("rst.last_data", ld_a, 0);
    chk("rst.b_store_count", 32'(sc_b), 0);

    // Pass sequence
    rst_pulse_a();
    qa.push_back(mk(1'b1, 2'b00, 16'd3, 1'b0, 16'd0, 32'd84, 32'h310));
    st_a(32'd80, 32'd7); st_a(32'd80, 32'd3); st_a(32'd84, 32'h310);
    wait_a(4);

    // Bad address, later pass store ignored
    rst_pulse_a();
    qa.push_back(mk(1'b0, 2'b01, 16'd1, 1'b0, 16'd0, 32'd88, 32'd0));
    st_a(32'd88, 32'd0);
    wait_a(4);
    st_a(32'd84, 32'h310);
    repeat (2) @(negedge clk);
    #1;
    chk("badaddr.sticky_done", 32'(done_a), 1);
    chk("badaddr.sticky_pass", 32'(pass_a), 0);
    chk("badaddr.sticky_code", 32'(fc_a), 1);
    chk("badaddr.sticky_count", 32'(sc_a), 1);
    chk("badaddr.sticky_addr", la_a, 88);

    // Bad data
    rst_pulse_a();
    qa.push_back(mk(1'b0, 2'b10, 16'd1, 1'b0, 16'd0, 32'd84, 32'd7));
    st_a(32'd84, 32'd7);
    wait_a(4);

    // Timeout with no stores: verdict after the 16th RUN edge
    rst_pulse_a();
    qa.push_back(mk(1'b0, 2'b11, 16'd0, 1'b1, 16'd15, 32'd0, 32'd0));
    repeat (15) @(negedge clk);
    #1;
    chk("tmo.done_before", 32'(done_a), 0);
    chk("tmo.cycle_before", 32'(cc_a), 15);
    wait_a(4);
    repeat (3) @(negedge clk);
    #1;
    chk("tmo.cycle_frozen", 32'(cc_a), 15);
    chk("tmo.code_sticky", 32'(fc_a), 3);

    // Pass store on the timeout edge wins
    rst_pulse_a();
    qa.push_back(mk(1'b1, 2'b00, 16'd1, 1'b0, 16'd0, 32'd84, 32'h310));
    repeat (15) @(negedge clk);
    st_a(32'd84, 32'h310);
    wait_a(4);

    // Asynchronous reset mid-run
    rst_pulse_a();
    st_a(32'd80, 32'd1); st_a(32'd80, 32'd2);
    #2;
    chk("async.count_before", 32'(sc_a), 2);
    rst_a = 1'b0;
    #1;
    chk("async.store_count", 32'(sc_a), 0);
    chk("async.cycle_count", 32'(cc_a), 0);
    chk("async.last_addr", la_a, 0);
    chk("async.last_data", ld_a, 0);
    chk("async.done", 32'(done_a), 0);
    @(negedge clk);
    rst_a = 1'b1;
    qa.push_back(mk(1'b1, 2'b00, 16'd1, 1'b0, 16'd0, 32'd84, 32'h310));
    st_a(32'd84, 32'h310);
    wait_a(4);

    // Small counters: scratch stores until timeout at cycle_count=14
    rst_pulse_b();
    qb.push_back(mk(1'b0, 2'b11, 16'd15, 1'b1, 16'd14, 32'd80, 32'd14));
    for (int i = 0; i < 20; i++) st_b(32'd80, 32'(i));
    wait_b(4);
    #1;
    chk("sat.store_count_held", 32'(sc_b), 15);
    chk("sat.cycle_count_held", 32'(cc_b), 14);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
